// File: rtl/nice_icb_pkg.sv
// Shared types for the NICE ICB outstanding buffer: command/response payloads
// and the hard ceiling on outstanding depth.
package nice_icb_pkg;
  localparam int NICE_OUTS_MAX = 16;
  localparam int NICE_DW       = 32;
  localparam int NICE_AW       = 32;

  typedef struct packed {
    logic [NICE_AW-1:0]   addr;
    logic                 read;
    logic [NICE_DW-1:0]   wdata;
    logic [NICE_DW/8-1:0] wmask;
  } icb_cmd_t;

  typedef struct packed {
    logic               err;
    logic [NICE_DW-1:0] rdata;
  } icb_rsp_t;
endpackage

// File: rtl/nice_icb_outs_buf_fifo.sv
// Registered synchronous FIFO with push/pop/full/empty/count; storage is
// not reset, only the pointers and the occupancy count are.
module nice_sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/nice_icb_outs_buf.sv
// Outstanding-transaction buffer between the NICE core ICB master and the LSU
// NICE port. Optional macro NICE_ICB_RSP_BYPASS_EN: zero-latency rsp when FIFO empty.
module nice_icb_outs_buf
  import nice_icb_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int OUTS_DEPTH = 4,
  localparam int CW        = $clog2(OUTS_DEPTH + 1)
) (
  input  logic          nice_clk,
  input  logic          nice_rst_n,
  input  logic          s_icb_cmd_valid,
  output logic          s_icb_cmd_ready,
  input  logic [AW-1:0] s_icb_cmd_addr,
  input  logic          s_icb_cmd_read,
  input  logic [DW-1:0] s_icb_cmd_wdata,
  input  logic [DW/8-1:0] s_icb_cmd_wmask,
  output logic          s_icb_rsp_valid,
  input  logic          s_icb_rsp_ready,
  output logic [DW-1:0] s_icb_rsp_rdata,
  output logic          s_icb_rsp_err,
  output logic          m_icb_cmd_valid,
  input  logic          m_icb_cmd_ready,
  output logic [AW-1:0] m_icb_cmd_addr,
  output logic          m_icb_cmd_read,
  output logic [DW-1:0] m_icb_cmd_wdata,
  output logic [DW/8-1:0] m_icb_cmd_wmask,
  input  logic          m_icb_rsp_valid,
  output logic          m_icb_rsp_ready,
  input  logic [DW-1:0] m_icb_rsp_rdata,
  input  logic          m_icb_rsp_err,
  output logic [CW-1:0] outs_cnt,
  output logic          outs_idle,
  output logic          unexp_rsp
);
  // Payload structs are fixed at the package widths.
  if (DW != NICE_DW || AW != NICE_AW || OUTS_DEPTH < 1 || OUTS_DEPTH > NICE_OUTS_MAX) begin : g_bad_cfg
    $error("nice_icb_outs_buf: unsupported DW/AW/OUTS_DEPTH");
  end

  icb_cmd_t      cmd;
  icb_rsp_t      m_rsp, f_dout, s_rsp;
  logic          full, cmd_hs, rsp_hs, unexp_now, byp, push, pop;
  logic          f_full, f_empty;
  logic [CW-1:0] f_cnt;

  assign cmd = '{addr: s_icb_cmd_addr, read: s_icb_cmd_read,
                 wdata: s_icb_cmd_wdata, wmask: s_icb_cmd_wmask};

  assign full            = (outs_cnt == CW'(OUTS_DEPTH));
  assign m_icb_cmd_valid = s_icb_cmd_valid & ~full;
  assign s_icb_cmd_ready = m_icb_cmd_ready & ~full;
  assign m_icb_cmd_addr  = cmd.addr;
  assign m_icb_cmd_read  = cmd.read;
  assign m_icb_cmd_wdata = cmd.wdata;
  assign m_icb_cmd_wmask = cmd.wmask;

  // Every issued command owns a FIFO slot, so the memory side is never stalled.
  assign m_icb_rsp_ready = nice_rst_n;
  assign m_rsp           = '{err: m_icb_rsp_err, rdata: m_icb_rsp_rdata};
  assign unexp_now       = m_icb_rsp_valid & (outs_cnt == '0);

`ifdef NICE_ICB_RSP_BYPASS_EN
  assign byp             = f_empty & s_icb_rsp_ready & m_icb_rsp_valid & ~unexp_now;
  assign s_icb_rsp_valid = ~f_empty | byp;
  assign s_rsp           = f_empty ? m_rsp : f_dout;
`else
  assign byp             = 1'b0;
  assign s_icb_rsp_valid = ~f_empty;
  assign s_rsp           = f_dout;
`endif

  assign s_icb_rsp_rdata = s_rsp.rdata;
  assign s_icb_rsp_err   = s_rsp.err;

  assign cmd_hs = m_icb_cmd_valid & m_icb_cmd_ready;
  assign rsp_hs = s_icb_rsp_valid & s_icb_rsp_ready;
  assign push   = m_icb_rsp_valid & ~unexp_now & ~byp;
  assign pop    = ~f_empty & s_icb_rsp_ready;

  nice_sync_fifo #(.T(icb_rsp_t), .DEPTH(OUTS_DEPTH)) u_rsp_fifo (
    .clk   (nice_clk),
    .rst_n (nice_rst_n),
    .push  (push),
    .din   (m_rsp),
    .pop   (pop),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_cnt)
  );

  always_ff @(posedge nice_clk or negedge nice_rst_n) begin
    if (!nice_rst_n) begin
      outs_cnt  <= '0;
      unexp_rsp <= 1'b0;
    end else begin
      outs_cnt  <= outs_cnt + CW'(cmd_hs) - CW'(rsp_hs);
      unexp_rsp <= unexp_now;
    end
  end

  assign outs_idle = (outs_cnt == '0) & f_empty;

  always_ff @(posedge nice_clk) begin
    if (nice_rst_n) begin
      assert (!(cmd_hs && !rsp_hs && outs_cnt == CW'(OUTS_DEPTH)));
      assert (!(rsp_hs && !cmd_hs && outs_cnt == '0));
      assert (!(push && f_full && !pop));
      assert (f_cnt <= outs_cnt);
    end
  end
endmodule

// File: tb/tb_nice_icb_outs_buf.sv
// Self-checking bench for nice_icb_outs_buf: directed scenarios plus a
// randomized run checked against a credit/queue reference model.
module tb_nice_icb_outs_buf;
  localparam int DW = 32, AW = 32, DEPTH = 4, CW = $clog2(DEPTH + 1);

  logic          nice_clk = 1'b0, nice_rst_n = 1'b0;
  logic          s_icb_cmd_valid = 0, s_icb_cmd_ready, s_icb_cmd_read = 0;
  logic [AW-1:0] s_icb_cmd_addr = '0;
  logic [DW-1:0] s_icb_cmd_wdata = '0;
  logic [3:0]    s_icb_cmd_wmask = '0;
  logic          s_icb_rsp_valid, s_icb_rsp_ready = 0, s_icb_rsp_err;
  logic [DW-1:0] s_icb_rsp_rdata;
  logic          m_icb_cmd_valid, m_icb_cmd_ready = 0, m_icb_cmd_read;
  logic [AW-1:0] m_icb_cmd_addr;
  logic [DW-1:0] m_icb_cmd_wdata;
  logic [3:0]    m_icb_cmd_wmask;
  logic          m_icb_rsp_valid = 0, m_icb_rsp_ready, m_icb_rsp_err = 0;
  logic [DW-1:0] m_icb_rsp_rdata = '0;
  logic [CW-1:0] outs_cnt;
  logic          outs_idle, unexp_rsp;

  int pass_cnt = 0, total_cnt = 0;

  nice_icb_outs_buf #(.DW(DW), .AW(AW), .OUTS_DEPTH(DEPTH)) dut (
    .nice_clk(nice_clk), .nice_rst_n(nice_rst_n),
    .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
    .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
    .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
    .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
    .s_icb_rsp_rdata(s_icb_rsp_rdata), .s_icb_rsp_err(s_icb_rsp_err),
    .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(m_icb_cmd_ready),
    .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
    .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
    .m_icb_rsp_valid(m_icb_rsp_valid), .m_icb_rsp_ready(m_icb_rsp_ready),
    .m_icb_rsp_rdata(m_icb_rsp_rdata), .m_icb_rsp_err(m_icb_rsp_err),
    .outs_cnt(outs_cnt), .outs_idle(outs_idle), .unexp_rsp(unexp_rsp)
  );

  always #5 nice_clk = ~nice_clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge nice_clk);
    @(negedge nice_clk);
  endtask

  task automatic test_reset();
    nice_rst_n = 1'b0;
    @(negedge nice_clk); #1;
    total_cnt += 5;
    if (outs_cnt !== 0) $display("FAIL reset_cnt got=%0d exp=0", outs_cnt); else pass_cnt++;
    if (s_icb_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", s_icb_rsp_valid); else pass_cnt++;
    if (unexp_rsp !== 1'b0) $display("FAIL reset_unexp got=%b exp=0", unexp_rsp); else pass_cnt++;
    if (outs_idle !== 1'b1) $display("FAIL reset_idle got=%b exp=1", outs_idle); else pass_cnt++;
    if (m_icb_rsp_ready !== 1'b0) $display("FAIL reset_m_rsp_ready got=%b exp=0", m_icb_rsp_ready); else pass_cnt++;
    nice_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    s_icb_cmd_valid = 1; s_icb_cmd_read = 1; s_icb_cmd_addr = 32'h8000_0010; m_icb_cmd_ready = 1;
    #1;
    total_cnt += 3;
    if (m_icb_cmd_valid !== 1'b1) $display("FAIL rd_m_cmd_valid got=%b exp=1", m_icb_cmd_valid); else pass_cnt++;
    if (m_icb_cmd_addr !== 32'h8000_0010) $display("FAIL rd_addr got=%h exp=80000010", m_icb_cmd_addr); else pass_cnt++;
    if (m_icb_cmd_read !== 1'b1) $display("FAIL rd_read got=%b exp=1", m_icb_cmd_read); else pass_cnt++;
    tick();
    s_icb_cmd_valid = 0;
    #1;
    total_cnt++;
    if (outs_cnt !== 1) $display("FAIL rd_cnt1 got=%0d exp=1", outs_cnt); else pass_cnt++;
    tick(); tick();
    m_icb_rsp_valid = 1; m_icb_rsp_rdata = 32'hDEAD_BEEF; m_icb_rsp_err = 0; s_icb_rsp_ready = 1;
    #1;
`ifdef NICE_ICB_RSP_BYPASS_EN
    total_cnt += 2;
    if (s_icb_rsp_valid !== 1'b1) $display("FAIL rd_byp_valid got=%b exp=1", s_icb_rsp_valid); else pass_cnt++;
    if (s_icb_rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_byp_data got=%h exp=deadbeef", s_icb_rsp_rdata); else pass_cnt++;
    tick();
    m_icb_rsp_valid = 0;
`else
    total_cnt++;
    if (s_icb_rsp_valid !== 1'b0) $display("FAIL rd_lat0_valid got=%b exp=0", s_icb_rsp_valid); else pass_cnt++;
    tick();
    m_icb_rsp_valid = 0;
    #1;
    total_cnt += 4;
    if (s_icb_rsp_valid !== 1'b1) $display("FAIL rd_lat1_valid got=%b exp=1", s_icb_rsp_valid); else pass_cnt++;
    if (s_icb_rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_data got=%h exp=deadbeef", s_icb_rsp_rdata); else pass_cnt++;
    if (s_icb_rsp_err !== 1'b0) $display("FAIL rd_err got=%b exp=0", s_icb_rsp_err); else pass_cnt++;
    if (outs_cnt !== 1) $display("FAIL rd_cnt_hold got=%0d exp=1", outs_cnt); else pass_cnt++;
    tick();
`endif
    s_icb_rsp_ready = 0;
    #1;
    total_cnt += 3;
    if (outs_cnt !== 0) $display("FAIL rd_cnt0 got=%0d exp=0", outs_cnt); else pass_cnt++;
    if (s_icb_rsp_valid !== 1'b0) $display("FAIL rd_done_valid got=%b exp=0", s_icb_rsp_valid); else pass_cnt++;
    if (outs_idle !== 1'b1) $display("FAIL rd_idle got=%b exp=1", outs_idle); else pass_cnt++;
  endtask

  task automatic test_outs_limit();
    s_icb_cmd_valid = 1; s_icb_cmd_read = 1; m_icb_cmd_ready = 1; s_icb_rsp_ready = 0;
    for (int i = 0; i < 6; i++) begin
      s_icb_cmd_addr = 32'h100 + 32'(i * 4);
      #1;
      total_cnt++;
      if (s_icb_cmd_ready !== (i < DEPTH)) $display("FAIL lim_ready%0d got=%b exp=%b", i, s_icb_cmd_ready, i < DEPTH); else pass_cnt++;
      tick();
    end
    #1;
    total_cnt += 2;
    if (outs_cnt !== DEPTH) $display("FAIL lim_cnt got=%0d exp=%0d", outs_cnt, DEPTH); else pass_cnt++;
    if (m_icb_cmd_valid !== 1'b0) $display("FAIL lim_m_valid got=%b exp=0", m_icb_cmd_valid); else pass_cnt++;
    m_icb_rsp_valid = 1; m_icb_rsp_rdata = 32'hA5;
    tick();
    m_icb_rsp_valid = 0;
    #1;
    total_cnt++;
    if (s_icb_cmd_ready !== 1'b0) $display("FAIL lim_still_full got=%b exp=0", s_icb_cmd_ready); else pass_cnt++;
    s_icb_rsp_ready = 1;
    tick();
    s_icb_rsp_ready = 0;
    #1;
    total_cnt++;
    if (s_icb_cmd_ready !== 1'b1) $display("FAIL lim_5th_ready got=%b exp=1", s_icb_cmd_ready); else pass_cnt++;
    tick();
    s_icb_cmd_valid = 0;
    #1;
    total_cnt++;
    if (outs_cnt !== DEPTH) $display("FAIL lim_refill got=%0d exp=%0d", outs_cnt, DEPTH); else pass_cnt++;
    s_icb_rsp_ready = 1; m_icb_rsp_valid = 1;
    repeat (DEPTH) tick();
    m_icb_rsp_valid = 0;
    tick(); tick();
    s_icb_rsp_ready = 0;
    #1;
    total_cnt++;
    if (outs_idle !== 1'b1) $display("FAIL lim_drain_idle got=%b exp=1", outs_idle); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    s_icb_cmd_valid = 1; m_icb_cmd_ready = 1; s_icb_rsp_ready = 0;
    tick(); tick();
    s_icb_cmd_valid = 0; m_icb_rsp_valid = 1; m_icb_rsp_rdata = 32'h77;
    tick();
    m_icb_rsp_valid = 0;
    #1;
    total_cnt += 2;
    if (outs_cnt !== 2) $display("FAIL same_pre_cnt got=%0d exp=2", outs_cnt); else pass_cnt++;
    if (s_icb_rsp_valid !== 1'b1) $display("FAIL same_pre_valid got=%b exp=1", s_icb_rsp_valid); else pass_cnt++;
    s_icb_cmd_valid = 1; s_icb_rsp_ready = 1;
    tick();
    s_icb_cmd_valid = 0; s_icb_rsp_ready = 0;
    #1;
    total_cnt++;
    if (outs_cnt !== 2) $display("FAIL same_cnt got=%0d exp=2", outs_cnt); else pass_cnt++;
    s_icb_rsp_ready = 1; m_icb_rsp_valid = 1;
    tick(); tick();
    m_icb_rsp_valid = 0;
    tick(); tick();
    s_icb_rsp_ready = 0;
    #1;
    total_cnt++;
    if (outs_idle !== 1'b1) $display("FAIL same_idle got=%b exp=1", outs_idle); else pass_cnt++;
  endtask

  task automatic test_hold_rsp();
    s_icb_cmd_valid = 1; m_icb_cmd_ready = 1; s_icb_rsp_ready = 0;
    repeat (4) tick();
    s_icb_cmd_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      m_icb_rsp_valid = 1; m_icb_rsp_rdata = 32'(k);
      #1;
      total_cnt++;
      if (m_icb_rsp_ready !== 1'b1) $display("FAIL hold_m_ready%0d got=%b exp=1", k, m_icb_rsp_ready); else pass_cnt++;
      tick();
    end
    m_icb_rsp_valid = 0;
    s_icb_rsp_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      total_cnt++;
      if (s_icb_rsp_valid !== 1'b1 || s_icb_rsp_rdata !== 32'(k))
        $display("FAIL hold_order%0d got=%b/%0d exp=1/%0d", k, s_icb_rsp_valid, s_icb_rsp_rdata, k);
      else pass_cnt++;
      tick();
    end
    s_icb_rsp_ready = 0;
    #1;
    total_cnt++;
    if (outs_idle !== 1'b1) $display("FAIL hold_idle got=%b exp=1", outs_idle); else pass_cnt++;
  endtask

  task automatic test_unexp_err();
    m_icb_rsp_valid = 1; m_icb_rsp_rdata = 32'h55;
    tick();
    m_icb_rsp_valid = 0;
    #1;
    total_cnt += 2;
    if (unexp_rsp !== 1'b1) $display("FAIL unexp_pulse got=%b exp=1", unexp_rsp); else pass_cnt++;
    if (s_icb_rsp_valid !== 1'b0) $display("FAIL unexp_valid got=%b exp=0", s_icb_rsp_valid); else pass_cnt++;
    tick();
    total_cnt += 3;
    if (unexp_rsp !== 1'b0) $display("FAIL unexp_end got=%b exp=0", unexp_rsp); else pass_cnt++;
    if (s_icb_rsp_valid !== 1'b0) $display("FAIL unexp_valid2 got=%b exp=0", s_icb_rsp_valid); else pass_cnt++;
    if (outs_cnt !== 0) $display("FAIL unexp_cnt got=%0d exp=0", outs_cnt); else pass_cnt++;
    s_icb_cmd_valid = 1; s_icb_cmd_read = 0; s_icb_cmd_wdata = 32'hCAFE_F00D; s_icb_cmd_wmask = 4'b0101;
    #1;
    total_cnt += 3;
    if (m_icb_cmd_read !== 1'b0) $display("FAIL wr_read got=%b exp=0", m_icb_cmd_read); else pass_cnt++;
    if (m_icb_cmd_wdata !== 32'hCAFE_F00D) $display("FAIL wr_wdata got=%h exp=cafef00d", m_icb_cmd_wdata); else pass_cnt++;
    if (m_icb_cmd_wmask !== 4'b0101) $display("FAIL wr_wmask got=%b exp=0101", m_icb_cmd_wmask); else pass_cnt++;
    tick();
    s_icb_cmd_valid = 0; m_icb_rsp_valid = 1; m_icb_rsp_err = 1;
    tick();
    m_icb_rsp_valid = 0; m_icb_rsp_err = 0;
    #1;
    total_cnt += 2;
    if (s_icb_rsp_valid !== 1'b1) $display("FAIL wr_rsp_valid got=%b exp=1", s_icb_rsp_valid); else pass_cnt++;
    if (s_icb_rsp_err !== 1'b1) $display("FAIL wr_err got=%b exp=1", s_icb_rsp_err); else pass_cnt++;
    s_icb_rsp_ready = 1;
    tick();
    s_icb_rsp_ready = 0;
  endtask

  task automatic test_reset_mid();
    s_icb_cmd_valid = 1; m_icb_cmd_ready = 1; s_icb_rsp_ready = 0;
    repeat (3) tick();
    s_icb_cmd_valid = 0; m_icb_rsp_valid = 1;
    tick();
    m_icb_rsp_valid = 0;
    #1;
    total_cnt += 2;
    if (outs_cnt !== 3) $display("FAIL rstmid_pre got=%0d exp=3", outs_cnt); else pass_cnt++;
    if (s_icb_rsp_valid !== 1'b1) $display("FAIL rstmid_pre_valid got=%b exp=1", s_icb_rsp_valid); else pass_cnt++;
    nice_rst_n = 1'b0;
    #1;
    total_cnt += 3;
    if (outs_cnt !== 0) $display("FAIL rstmid_cnt got=%0d exp=0", outs_cnt); else pass_cnt++;
    if (s_icb_rsp_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", s_icb_rsp_valid); else pass_cnt++;
    if (outs_idle !== 1'b1) $display("FAIL rstmid_idle got=%b exp=1", outs_idle); else pass_cnt++;
    tick();
    nice_rst_n = 1'b1;
    tick();
  endtask

  // Reference: outstanding = issued - delivered; memory answers issued
  // commands in order; the core receives returned beats in arrival order.
  task automatic test_random();
    logic [DW:0] pend_q[$], ret_q[$];
    int mcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      logic full_e, issued, deliv, byp_e;
      logic [DW:0] got, exp_v;
      s_icb_cmd_valid = ($urandom_range(0, 2) != 0);
      s_icb_cmd_read  = $urandom_range(0, 1);
      s_icb_cmd_addr  = $urandom;
      s_icb_cmd_wdata = $urandom;
      s_icb_cmd_wmask = 4'($urandom);
      m_icb_cmd_ready = ($urandom_range(0, 3) != 0);
      s_icb_rsp_ready = ($urandom_range(0, 2) != 0);
      m_icb_rsp_valid = (pend_q.size() > 0) && ($urandom_range(0, 1) == 1);
      {m_icb_rsp_err, m_icb_rsp_rdata} = (pend_q.size() > 0) ? pend_q[0] : '0;
      #1;
      full_e = (mcnt == DEPTH);
`ifdef NICE_ICB_RSP_BYPASS_EN
      byp_e = (ret_q.size() == 0) && s_icb_rsp_ready && m_icb_rsp_valid;
`else
      byp_e = 1'b0;
`endif
      issued = s_icb_cmd_valid && m_icb_cmd_ready && !full_e;
      deliv  = s_icb_rsp_ready && (ret_q.size() > 0 || byp_e);
      total_cnt += 5;
      if (s_icb_cmd_ready !== (m_icb_cmd_ready && !full_e)) $display("FAIL rnd_cmd_ready c=%0d got=%b exp=%b", c, s_icb_cmd_ready, m_icb_cmd_ready && !full_e); else pass_cnt++;
      if (m_icb_cmd_valid !== (s_icb_cmd_valid && !full_e)) $display("FAIL rnd_cmd_valid c=%0d got=%b exp=%b", c, m_icb_cmd_valid, s_icb_cmd_valid && !full_e); else pass_cnt++;
      if (outs_cnt !== CW'(mcnt)) $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, outs_cnt, mcnt); else pass_cnt++;
      if (outs_idle !== (mcnt == 0)) $display("FAIL rnd_idle c=%0d got=%b exp=%b", c, outs_idle, mcnt == 0); else pass_cnt++;
      if (s_icb_rsp_valid !== (ret_q.size() > 0 || byp_e)) $display("FAIL rnd_rsp_valid c=%0d got=%b exp=%b", c, s_icb_rsp_valid, ret_q.size() > 0 || byp_e); else pass_cnt++;
      if (deliv) begin
        got   = {s_icb_rsp_err, s_icb_rsp_rdata};
        exp_v = byp_e ? pend_q[0] : ret_q[0];
        total_cnt++;
        if (got !== exp_v) $display("FAIL rnd_rsp_data c=%0d got=%h exp=%h", c, got, exp_v); else pass_cnt++;
      end
      @(posedge nice_clk);
      if (deliv && !byp_e) void'(ret_q.pop_front());
      if (m_icb_rsp_valid) begin
        if (byp_e) void'(pend_q.pop_front());
        else ret_q.push_back(pend_q.pop_front());
      end
      if (issued) pend_q.push_back({1'($urandom_range(0, 7) == 0), DW'($urandom)});
      mcnt = mcnt + int'(issued) - int'(deliv);
      @(negedge nice_clk);
    end
    s_icb_cmd_valid = 0; m_icb_rsp_valid = 0; s_icb_rsp_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_outs_limit();
    test_same_cycle();
    test_hold_rsp();
    test_unexp_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
